monitor_symbol_feeder: RTL

- Producer end of the automata-stage symbol interface: accepts 8-bit trace symbols from the core-side monitor tap over a valid/ready handshake.
- Buffers the symbols in a FIFO and drives the symbol/run/reset inputs of the first automata stage of a cluster.
- Sequences the automata reset at the start of each trace, then issues one symbol per `run` cycle, with optional pause via `hold`.

---
 rtl/monitor_symbol_feeder_if.sv | 12 +
 rtl/monitor_symbol_feeder.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/monitor_symbol_feeder_if.sv
// Upstream symbol handshake from the core-side monitor tap into the feeder.
// The master drives valid/symbol, the slave (feeder) answers with ready.
interface monitor_symbol_feeder_if #(
    parameter int SYM_W = 8
) ();
    logic             in_valid;
    logic [SYM_W-1:0] in_symbol;
    logic             in_ready;

    modport master (output in_valid, output in_symbol, input in_ready);
    modport slave  (input in_valid, input in_symbol, output in_ready);
endinterface

// File: rtl/monitor_symbol_feeder.sv
// Feeds buffered trace symbols into stage 0 of an automata cluster.
// Sequences the automata reset at trace start, then issues one symbol per run cycle.
module monitor_symbol_feeder #(
    parameter int SYM_W      = 8,
    parameter int DEPTH      = 16,
    parameter int RST_CYCLES = 2,
    parameter int CNT_W      = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start_trace,
    monitor_symbol_feeder_if.slave   up,
    input  logic                     hold,
    output logic [SYM_W-1:0]         top_symbols,
    output logic                     run,
    output logic                     out_reset,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [CNT_W-1:0]         sym_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int RC_W  = $clog2(RST_CYCLES + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RST    = 2'd1;
    localparam logic [1:0] ST_STREAM = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [RC_W-1:0]  rst_cnt_q, rst_cnt_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [SYM_W-1:0] top_q, top_d;
    logic             run_q, run_d;
    logic             out_reset_q, out_reset_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SYM_W-1:0] mem_q [DEPTH];

    logic in_ready_w;
    logic push;
    logic pop;

    // Ready comes from registered state only, so there is no path from in_valid.
    assign in_ready_w = (state_q == ST_STREAM) && (level_q < LVL_W'(DEPTH));
    assign push       = up.in_valid && in_ready_w && !start_trace;
    assign pop        = (state_q == ST_STREAM) && (level_q != '0) && !hold && !start_trace;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d     = state_q;
        rst_cnt_d   = rst_cnt_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        top_d       = top_q;
        run_d       = 1'b0;
        out_reset_d = 1'b0;
        cnt_d       = cnt_q;

        case (state_q)
            ST_IDLE:   ;
            ST_RST: begin
                out_reset_d = 1'b1;
                if (rst_cnt_q == RC_W'(RST_CYCLES - 1)) begin
                    state_d     = ST_STREAM;
                    out_reset_d = 1'b0;
                end else begin
                    rst_cnt_d = rst_cnt_q + 1'b1;
                end
            end
            ST_STREAM: ;
            default:   state_d = ST_IDLE;
        endcase

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            top_d    = mem_q[rd_ptr_q];
            run_d    = 1'b1;
            if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        // A new trace wins over everything except reset: flush and restart the pulse.
        if (start_trace) begin
            state_d     = ST_RST;
            rst_cnt_d   = '0;
            out_reset_d = 1'b1;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            level_d     = '0;
            cnt_d       = '0;
            run_d       = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            rst_cnt_q   <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            top_q       <= '0;
            run_q       <= 1'b0;
            out_reset_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            rst_cnt_q   <= rst_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            top_q       <= top_d;
            run_q       <= run_d;
            out_reset_q <= out_reset_d;
            cnt_q       <= cnt_d;
        end
    end

    // NOTE: storage is deliberately not reset; level and pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= up.in_symbol;
    end

    assign up.in_ready  = in_ready_w;
    assign top_symbols  = top_q;
    assign run          = run_q;
    assign out_reset    = out_reset_q;
    assign busy         = (state_q == ST_RST) || (level_q != '0);
    assign fifo_level   = level_q;
    assign sym_count    = cnt_q;

endmodule
